// File: rtl/seq_ctrl_pkg.sv
// Shared types and helpers for the C/B/A + J/K handshake sequencer.
// State encoding, default repeat counts and the B-length clamp.
package seq_ctrl_pkg;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      S_C  = 3'd1,
      S_B  = 3'd2,
      S_A  = 3'd3,
      S_J  = 3'd4,
      S_K  = 3'd5,
      S_X  = 3'd6
   } state_t;

   localparam int BMAX_DEF = 3;
   localparam int JLEN_DEF = 4;

   // A zero request still produces one B cycle; anything above bmax saturates.
   function automatic logic [1:0] clamp_blen(input logic [1:0] blen, input int bmax);
      logic [1:0] b;
      b = (blen == 2'd0) ? 2'd1 : blen;
      if (int'(b) > bmax) b = 2'(bmax);
      return b;
   endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter; pointer remembers the last winner.
// Combinational grant, gated by en; the pointer advances only on a grant.
module rr_arb2 (
   input  logic       CLK,
   input  logic       RSTN,
   input  logic       en,
   input  logic [1:0] req,
   output logic [1:0] gnt
);

   logic ptr;

   always_comb begin
      gnt = 2'b00;
      if (en) begin
         if (req == 2'b11) gnt = ptr ? 2'b01 : 2'b10;
         else              gnt = req;
      end
   end

   // Reset to 1 so requester 0 wins the first tie.
   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN)      ptr <= 1'b1;
      else if (|gnt)  ptr <= gnt[1];
   end

endmodule

// File: rtl/seq_proto_ctrl.sv
// Moore sequencer driving C, B[*1:BMAX], A, J[*JLEN], K (or X on abort) for two requesters.
// C appears one cycle after req is sampled in IDLE; req is ignored while busy.
module seq_proto_ctrl
   import seq_ctrl_pkg::*;
#(
   parameter int BMAX = BMAX_DEF,
   parameter int JLEN = JLEN_DEF
) (
   input  logic       CLK,
   input  logic       RSTN,
   input  logic [1:0] req,
   input  logic [1:0] blen0,
   input  logic [1:0] blen1,
   input  logic       abort,
   output logic       A,
   output logic       B,
   output logic       C,
   output logic       J,
   output logic       K,
   output logic       X,
   output logic [1:0] gnt,
   output logic       busy,
   output logic       done
);

   localparam int JW = $clog2(JLEN + 1);

   state_t          state_q, state_n;
   logic [1:0]      bcnt;
   logic [JW-1:0]   jcnt;
   logic [1:0]      gnt_q;
   logic [1:0]      arb_gnt;
   logic            idle;

   assign idle = (state_q == IDLE);

   rr_arb2 u_arb (
      .CLK  (CLK),
      .RSTN (RSTN),
      .en   (idle),
      .req  (req),
      .gnt  (arb_gnt)
   );

   always_comb begin
      state_n = state_q;
      case (state_q)
         IDLE: if (|arb_gnt) state_n = S_C;
         S_C:  state_n = abort ? S_X : S_B;
         S_B:  if (abort) state_n = S_X;
               else if (bcnt <= 2'd1) state_n = S_A;
         S_A:  state_n = abort ? S_X : S_J;
         // Abort takes priority even on the last J cycle.
         S_J:  if (abort) state_n = S_X;
               else if (jcnt <= JW'(1)) state_n = S_K;
         S_K:  state_n = IDLE;
         S_X:  state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         state_q <= IDLE;
         bcnt    <= 2'd0;
         jcnt    <= '0;
         gnt_q   <= 2'b00;
      end else begin
         state_q <= state_n;

         if (idle && |arb_gnt)
            bcnt <= clamp_blen(arb_gnt[1] ? blen1 : blen0, BMAX);
         else if (state_q == S_B && bcnt != 2'd0)
            bcnt <= bcnt - 2'd1;

         if (state_n == S_J && state_q != S_J)
            jcnt <= JW'(JLEN);
         else if (state_q == S_J && jcnt != '0)
            jcnt <= jcnt - JW'(1);

         // Grant is held through the closing K or X cycle.
         if (state_n == IDLE) gnt_q <= 2'b00;
         else if (idle)       gnt_q <= arb_gnt;
      end
   end

   assign C    = (state_q == S_C);
   assign B    = (state_q == S_B);
   assign A    = (state_q == S_A);
   assign J    = (state_q == S_J);
   assign K    = (state_q == S_K);
   assign X    = (state_q == S_X);
   assign done = (state_q == S_K);
   assign busy = !idle;
   assign gnt  = gnt_q;

endmodule

// File: tb/tb_seq_proto_ctrl.sv
// Directed bench for seq_proto_ctrl: per-cycle strobe checks against a hand-derived sequence shape.
// A second instance with BMAX=2 runs alongside to check clamping.
module tb_seq_proto_ctrl;

   logic       CLK;
   logic       RSTN;
   logic [1:0] req;
   logic [1:0] blen0, blen1;
   logic       abort;

   logic       A1, B1, C1, J1, K1, X1, busy1, done1;
   logic [1:0] gnt1;
   logic       A2, B2, C2, J2, K2, X2, busy2, done2;
   logic [1:0] gnt2;

   logic [9:0] out1, out2;
   assign out1 = {C1, B1, A1, J1, K1, X1, done1, busy1, gnt1};
   assign out2 = {C2, B2, A2, J2, K2, X2, done2, busy2, gnt2};

   int tests = 0;
   int fails = 0;

   seq_proto_ctrl #(.BMAX(3), .JLEN(4)) u_dut (
      .CLK(CLK), .RSTN(RSTN), .req(req), .blen0(blen0), .blen1(blen1), .abort(abort),
      .A(A1), .B(B1), .C(C1), .J(J1), .K(K1), .X(X1),
      .gnt(gnt1), .busy(busy1), .done(done1)
   );

   seq_proto_ctrl #(.BMAX(2), .JLEN(4)) u_dut2 (
      .CLK(CLK), .RSTN(RSTN), .req(req), .blen0(blen0), .blen1(blen1), .abort(abort),
      .A(A2), .B(B2), .C(C2), .J(J2), .K(K2), .X(X2),
      .gnt(gnt2), .busy(busy2), .done(done2)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   typedef struct {
      logic [1:0] req;
      logic [1:0] b0;
      logic [1:0] b1;
      logic [1:0] g;
      int         nb;
      int         nb2;
   } rec_t;

   rec_t tbl[5];

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic chk(input string nm, input logic [9:0] act, input logic [9:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s @%0t: got {C,B,A,J,K,X,done,busy,gnt}=%b expected %b", nm, $time, act, exp);
      end
   endtask

   task automatic chk_int(input string nm, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s @%0t: got %0d expected %0d", nm, $time, act, exp);
      end
   endtask

   // Expected outputs in cycle i of a sequence with nb B cycles and JLEN=4.
   function automatic logic [9:0] exp_vec(input int i, input int nb, input logic [1:0] g);
      logic [5:0] s;
      logic       d;
      d = 1'b0;
      if (i == 0)            s = 6'b100000;
      else if (i <= nb)      s = 6'b010000;
      else if (i == nb + 1)  s = 6'b001000;
      else if (i <= nb + 5)  s = 6'b000100;
      else begin
         s = 6'b000010;
         d = 1'b1;
      end
      return {s, d, 1'b1, g};
   endfunction

   // Entered in the C cycle. ab is the cycle index at which abort is raised (-1: none).
   // nb2 >= 0 also checks the BMAX=2 instance's B and K counts over the same window.
   task automatic run_seq(input string nm, input logic [1:0] g, input int nb,
                          input int nb2, input int ab);
      int  last, b2, k2;
      bit  ab_hit;
      ab_hit = (ab >= 0 && ab < nb + 6);
      last   = ab_hit ? ab : nb + 6;
      b2 = 0;
      k2 = 0;
      for (int i = 0; i <= last; i++) begin
         chk(nm, out1, exp_vec(i, nb, g));
         b2 += int'(B2);
         k2 += int'(K2);
         if (i == 0) req = req & ~g;
         if (i == ab) abort = 1'b1;
         step();
         abort = 1'b0;
      end
      if (ab_hit) begin
         chk({nm, "_x"}, out1, {6'b000001, 1'b0, 1'b1, g});
         step();
      end
      chk({nm, "_gap"}, out1, 10'd0);
      b2 += int'(B2);
      k2 += int'(K2);
      if (nb2 >= 0) begin
         chk_int({nm, "_bmax2_bcount"}, b2, nb2);
         chk_int({nm, "_bmax2_kcount"}, k2, 1);
      end
   endtask

   initial begin
      RSTN  = 1'b0;
      req   = 2'b00;
      blen0 = 2'd0;
      blen1 = 2'd0;
      abort = 1'b0;

      tbl[0] = '{req: 2'b10, b0: 2'd1, b1: 2'd3, g: 2'b10, nb: 3, nb2: 2};
      tbl[1] = '{req: 2'b10, b0: 2'd2, b1: 2'd0, g: 2'b10, nb: 1, nb2: 1};
      tbl[2] = '{req: 2'b01, b0: 2'd2, b1: 2'd3, g: 2'b01, nb: 2, nb2: 2};
      tbl[3] = '{req: 2'b01, b0: 2'd3, b1: 2'd1, g: 2'b01, nb: 3, nb2: 2};
      tbl[4] = '{req: 2'b10, b0: 2'd0, b1: 2'd2, g: 2'b10, nb: 2, nb2: 2};

      step();
      step();
      chk("reset_state", out1, 10'd0);
      chk("reset_state_dut2", out2, 10'd0);
      RSTN = 1'b1;

      // Reset asserted in the middle of the J phase.
      req   = 2'b10;
      blen1 = 2'd1;
      step();
      for (int i = 0; i <= 4; i++) begin
         chk("pre_reset_seq", out1, exp_vec(i, 1, 2'b10));
         if (i == 0) req = 2'b00;
         if (i < 4) step();
      end
      RSTN = 1'b0;
      #1;
      chk("async_reset_mid_j", out1, 10'd0);
      chk("async_reset_mid_j_dut2", out2, 10'd0);
      step();
      chk("reset_held", out1, 10'd0);
      RSTN  = 1'b1;
      req   = 2'b01;
      blen0 = 2'd1;
      step();
      run_seq("seq01_b1", 2'b01, 1, 1, -1);

      for (int t = 0; t < 5; t++) begin
         req   = tbl[t].req;
         blen0 = tbl[t].b0;
         blen1 = tbl[t].b1;
         step();
         run_seq($sformatf("tbl%0d", t), tbl[t].g, tbl[t].nb, tbl[t].nb2, -1);
      end

      // Both requesters held from reset: 0 first, one gap cycle, then 1.
      RSTN = 1'b0;
      step();
      RSTN  = 1'b1;
      req   = 2'b11;
      blen0 = 2'd2;
      blen1 = 2'd1;
      step();
      run_seq("rr_first", 2'b01, 2, -1, -1);
      step();
      run_seq("rr_second", 2'b10, 1, -1, -1);

      // Abort in the second B cycle; pointer must still have moved to 0.
      req   = 2'b01;
      blen0 = 2'd3;
      step();
      run_seq("abort_b2", 2'b01, 3, -1, 2);
      req   = 2'b11;
      blen1 = 2'd1;
      step();
      run_seq("ptr_after_abort", 2'b10, 1, -1, -1);

      // Abort coinciding with the last J cycle wins over K.
      req   = 2'b01;
      blen0 = 2'd1;
      step();
      run_seq("abort_last_j", 2'b01, 1, -1, 6);

      // Abort in S_K is ignored.
      req   = 2'b10;
      blen1 = 2'd2;
      step();
      run_seq("abort_in_k", 2'b10, 2, -1, 8);

      // Abort in IDLE is ignored.
      abort = 1'b1;
      step();
      chk("abort_idle", out1, 10'd0);
      abort = 1'b0;
      step();
      chk("abort_idle_after", out1, 10'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
